// File: rtl/wait_timer.sv
// wait_timer: loadable/addable saturating wait counter, manual or prescaled auto decrement, pause/abort; ports ck rst_n load_wait add_wait dec_wait auto_mode pause abort new_count -> count end_wait done_pulse busy state
module wait_timer #(
  parameter int CNT_W = 4,
  parameter int PRESC_DIV = 50000
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             load_wait,
  input  logic             add_wait,
  input  logic             dec_wait,
  input  logic             auto_mode,
  input  logic             pause,
  input  logic             abort,
  input  logic [CNT_W-1:0] new_count,
  output logic [CNT_W-1:0] count,
  output logic             end_wait,
  output logic             done_pulse,
  output logic             busy,
  output logic [1:0]       state
);
  localparam int PW = PRESC_DIV > 1 ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(PRESC_DIV - 1);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSED = 2'b10, DONE = 2'b11} state_t;
  state_t st_q, st_d;
  logic [CNT_W-1:0] cnt_d, add_res;
  logic [CNT_W:0] sum;
  logic [PW-1:0] presc, pre_d;
  logic done_d, tick, dec;
  assign tick = presc == P_MAX;
  assign dec = auto_mode ? tick : dec_wait;
  assign sum = {1'b0, count} + {1'b0, new_count};
  assign add_res = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  assign end_wait = count == '0;
  assign busy = st_q == RUN || st_q == PAUSED;
  assign state = st_q;
  always_comb begin
    st_d = st_q;
    cnt_d = count;
    done_d = 1'b0;
    if (abort) begin
      st_d = IDLE;
      cnt_d = '0;
    end else if (load_wait) begin
      cnt_d = new_count;
      st_d = new_count != '0 ? RUN : DONE;
      done_d = new_count == '0;
    end else if (add_wait) begin
      cnt_d = add_res;
      st_d = (add_res == '0 || st_q == PAUSED) ? st_q : RUN;
    end else if (st_q == RUN && pause) begin
      st_d = PAUSED;
    end else if (st_q == RUN && dec && count != '0) begin
      cnt_d = count - 1'b1;
      st_d = count == CNT_W'(1) ? DONE : RUN;
      done_d = count == CNT_W'(1);
    end else if (st_q == PAUSED && !pause) begin
      st_d = RUN;
    end
  end
  // prescaler only runs in unpaused auto RUN; add_wait leaves it untouched
  always_comb begin
    pre_d = presc;
    if (abort || load_wait || !auto_mode || st_q == IDLE || st_q == DONE)
      pre_d = '0;
    else if (st_q == RUN && !pause && !add_wait)
      pre_d = tick ? '0 : presc + 1'b1;
  end
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= IDLE;
      count <= '0;
      presc <= '0;
      done_pulse <= 1'b0;
    end else begin
      st_q <= st_d;
      count <= cnt_d;
      presc <= pre_d;
      done_pulse <= done_d;
    end
  end
endmodule

// File: tb/tb_wait_timer.sv
// tb_wait_timer: directed self-checking bench for wait_timer with CNT_W=4, PRESC_DIV=4
module tb_wait_timer;
  logic ck = 1'b0;
  logic rst_n, load_wait, add_wait, dec_wait, auto_mode, pause, abort;
  logic [3:0] new_count, count;
  logic end_wait, done_pulse, busy;
  logic [1:0] state;
  int n_cmp = 0;
  int n_err = 0;
  always #5 ck = ~ck;
  wait_timer #(.CNT_W(4), .PRESC_DIV(4)) dut (
    .ck(ck), .rst_n(rst_n), .load_wait(load_wait), .add_wait(add_wait),
    .dec_wait(dec_wait), .auto_mode(auto_mode), .pause(pause), .abort(abort),
    .new_count(new_count), .count(count), .end_wait(end_wait),
    .done_pulse(done_pulse), .busy(busy), .state(state)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge ck);
    #1;
  endtask
  task automatic look(input string tag, input int c, input int s, input int d);
    check({tag, "_count"}, 32'(count), 32'(c));
    check({tag, "_state"}, 32'(state), 32'(s));
    check({tag, "_done"}, 32'(done_pulse), 32'(d));
    check({tag, "_end"}, 32'(end_wait), 32'(c == 0));
    check({tag, "_busy"}, 32'(busy), 32'(s == 1 || s == 2));
  endtask
  task automatic load(input int v);
    load_wait = 1'b1;
    new_count = 4'(v);
    step();
    load_wait = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    {load_wait, add_wait, dec_wait, auto_mode, pause, abort} = '0;
    new_count = '0;
    #1;
    look("reset", 0, 0, 0);
    #12 rst_n = 1'b1;
    step();
    look("idle_hold", 0, 0, 0);
    dec_wait = 1'b1;
    step();
    look("idle_dec_ignored", 0, 0, 0);
    dec_wait = 1'b0;
    load(3);
    look("man_load3", 3, 1, 0);
    dec_wait = 1'b1;
    step();
    look("man_2", 2, 1, 0);
    step();
    look("man_1", 1, 1, 0);
    step();
    look("man_0", 0, 3, 1);
    step();
    look("done_dec_ignored", 0, 3, 0);
    dec_wait = 1'b0;
    auto_mode = 1'b1;
    load(2);
    look("auto_load2", 2, 1, 0);
    dec_wait = 1'b1;
    repeat (3) step();
    look("auto_3edges", 2, 1, 0);
    dec_wait = 1'b0;
    step();
    look("auto_4edges", 1, 1, 0);
    dec_wait = 1'b1;
    repeat (3) step();
    look("auto_7edges", 1, 1, 0);
    step();
    look("auto_8edges", 0, 3, 1);
    dec_wait = 1'b0;
    auto_mode = 1'b0;
    load(12);
    look("sat_load12", 12, 1, 0);
    add_wait = 1'b1;
    new_count = 4'd9;
    step();
    add_wait = 1'b0;
    look("sat_add9", 15, 1, 0);
    load(0);
    look("load0", 0, 3, 1);
    add_wait = 1'b1;
    new_count = 4'd3;
    step();
    add_wait = 1'b0;
    look("add_from_done", 3, 1, 0);
    auto_mode = 1'b1;
    load(1);
    step();
    step();
    look("pause_pre", 1, 1, 0);
    pause = 1'b1;
    step();
    look("pause_enter", 1, 2, 0);
    repeat (4) step();
    look("pause_held", 1, 2, 0);
    pause = 1'b0;
    step();
    look("pause_resume", 1, 1, 0);
    step();
    look("pause_active1", 1, 1, 0);
    step();
    look("pause_active2", 0, 3, 1);
    auto_mode = 1'b0;
    load(4);
    abort = 1'b1;
    load(7);
    abort = 1'b0;
    look("abort_load", 0, 0, 0);
    add_wait = 1'b1;
    load(5);
    add_wait = 1'b0;
    look("load_add", 5, 1, 0);
    @(negedge ck);
    rst_n = 1'b0;
    #1;
    look("async_reset", 0, 0, 0);
    #2 rst_n = 1'b1;
    step();
    look("post_reset", 0, 0, 0);
    load(2);
    dec_wait = 1'b1;
    step();
    step();
    dec_wait = 1'b0;
    look("resume_countdown", 0, 3, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
